// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and clock/baud constants
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned BAUD_RATE         = 9600;
    localparam int unsigned BAUD_DIV_DEFAULT  = CLK_HZ / BAUD_RATE;

    // Line phases of one 8N1 frame
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - modulo-DIV bit-period counter with synchronous clear and tick
module baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned       CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count 0..DIV-1 and wrap; clear holds the counter at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Tick marks the last cycle of each bit period
    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with registered outputs and end-of-frame pulse
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sttx_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   txd_o,
    output logic                   busy_o,
    output logic                   eot_o
);

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]             idx_q, idx_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   eot_q, eot_d;
    logic                   tick;

    // Bit timer is held cleared while idle so a new frame starts at count 0
    baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; outputs are precomputed so they change on the same edge as the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            eot_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            eot_q   <= eot_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        eot_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (sttx_i) begin
                    state_d = ST_START;
                    shreg_d = data_i;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    txd_d   = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // bit 1 becomes the new LSB after this shift
                        txd_d   = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    eot_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;
    assign eot_o  = eot_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb/tb_uart_tx_8n1.sv - randomized self-checking bench for uart_tx_8n1
module tb_uart_tx_8n1;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sttx  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       txd, busy, eot;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_8n1 #(
        .BAUD_DIV (D)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sttx_i (sttx),
        .data_i (data),
        .txd_o  (txd),
        .busy_o (busy),
        .eot_o  (eot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level for frame bit i: start, 8 data bits LSB first, stop
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    // Reference model: frame age in cycles since the accepting edge
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_eot    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_eot    <= 1'b0;
        end else if (m_active) begin
            m_eot <= 1'b0;
            if (m_t == 10 * D - 1) begin
                m_active <= 1'b0;
                m_eot    <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            m_eot <= 1'b0;
            if (sttx) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_byte   <= data;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("txd",  32'(txd),  32'(m_active ? exp_bit(m_byte, m_t / D) : 1'b1));
        check("busy", 32'(busy), 32'(m_active));
        check("eot",  32'(eot),  32'(m_eot));
    end

    // Line decoder: samples mid-bit after each falling edge
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte = 8'h00;
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic       rx_prev = 1'b1;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= txd;
            if (!rx_busy) begin
                if (rx_prev && !txd) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt % D == D / 2) begin
                    if (rx_cnt / D >= 1 && rx_cnt / D <= 8) begin
                        rx_byte[rx_cnt / D - 1] <= txd;
                    end else if (rx_cnt / D == 9) begin
                        rx_q.push_back(rx_byte);
                        rx_busy <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        sttx = 1'b1;
        data = b;
        @(negedge clk);
        sttx = 1'b0;
        data = 8'($urandom);
    endtask

    task automatic wait_eot(output int cycles);
        cycles = 0;
        while (!eot && cycles < 10 * D + 5) begin
            @(negedge clk);
            cycles++;
        end
        if (!eot) check("eot_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int         cyc;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_txd",  32'(txd),  32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_eot",  32'(eot),  32'(0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        // Single frame then back-to-back in the eot cycle
        rx_q.delete();
        send(8'h79);
        wait_eot(cyc);
        check("busy_len", 32'(cyc), 32'(10 * D));
        send(8'h6F);
        check("b2b_start", 32'(txd), 32'(0));
        wait_eot(cyc);
        check("b2b_len", 32'(cyc), 32'(10 * D));
        exp_q = '{8'h79, 8'h6F};
        check_rx("single_b2b", exp_q);

        // Request and data changes while busy are ignored
        repeat (3) @(negedge clk);
        rx_q.delete();
        send(8'hA5);
        repeat (13) @(negedge clk);
        send(8'hFF);
        repeat (5) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        wait_eot(cyc);
        repeat (50) @(negedge clk);
        check("busy_ign_idle", 32'(busy), 32'(0));
        exp_q = '{8'hA5};
        check_rx("busy_ignore", exp_q);

        // Reset during data bit 3, then a clean frame
        send(8'h3C);
        repeat (4 * D + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_txd",  32'(txd),  32'(1));
        check("midrst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        rx_q.delete();
        send(8'hC3);
        wait_eot(cyc);
        check("post_rst_len", 32'(cyc), 32'(10 * D));
        exp_q = '{8'hC3};
        check_rx("post_rst", exp_q);

        // "yoye" string sequencer
        repeat (2) @(negedge clk);
        rx_q.delete();
        exp_q = '{8'h79, 8'h6F, 8'h79, 8'h65};
        foreach (exp_q[i]) begin
            send(exp_q[i]);
            wait_eot(cyc);
        end
        check_rx("yoye", exp_q);

        // Random bytes, random gaps, random requests while busy
        repeat (2) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                send(8'($urandom));
            end
            wait_eot(cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_rx("random", exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
